// File: rtl/mem_pkg.sv
// Shared types, default sizes and parameter checks for the memory/writeback stage.
package mem_pkg;

  // Stage FSM: idle/single-cycle completion, or counting out a multi-cycle load.
  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned BYTES      = DEF_DATA_W / 8;
  localparam int unsigned IDX_W      = $clog2(DEF_DEPTH);

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Byte lanes in a word of the given width.
  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Legal load latency range.
  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem.sv
// dmem_bytewr: byte-enabled synchronous-write, asynchronous-read word array.
// Contents are intentionally not reset.
module dmem_bytewr #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int unsigned N_LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(N_LANES); i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data memory access plus writeback registers with configurable
// load latency, stall handshake, flush and bubble insertion.
// Optional feature macro: MEM_BOUNDS_CHK_EN (out-of-range detection, err_w).
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic [DATA_W/8-1:0]   byte_en_m,
  input  logic [31:0]           alu_out_m,
  input  logic [DATA_W-1:0]     write_data_m,
  input  logic                  flush_m,
  output logic                  stall_m,
  output logic                  valid_w,
  output logic [31:0]           alu_out_w,
  output logic [DATA_W-1:0]     read_data_w,
  output logic                  err_w
);

  localparam int unsigned N_BYTES = bytes_of(DATA_W);
  localparam int unsigned OFF_W   = $clog2(N_BYTES);
  localparam int unsigned IDX_LEN = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(RD_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam bit MULTI = (RD_LAT > 1);

  // Elaboration-time parameter sanity checks.
  generate
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("mem_wb_stage: RD_LAT must be within 1..4");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("mem_wb_stage: DATA_W must be a multiple of 8");
    end
  endgenerate

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_LEN-1:0]   idx;
  logic                 in_range;
  logic                 pending;
  logic                 at_last;
  logic                 complete;
  logic                 is_mem;
  logic                 we;
  logic [DATA_W-1:0]    rdata;

  assign idx = alu_out_m[OFF_W +: IDX_LEN];

`ifdef MEM_BOUNDS_CHK_EN
  // Any word-index bit above the array depth marks the access out of range.
  assign in_range = ((alu_out_m >> (OFF_W + IDX_LEN)) == 32'd0);
`else
  // Index is truncated: accesses wrap modulo DEPTH words.
  assign in_range = 1'b1;
`endif

  assign is_mem   = mem_read_m | mem_write_m;
  assign pending  = valid_m & mem_read_m & ~flush_m;
  assign at_last  = (state == LOAD_WAIT) && (cnt == CNT_LAST);
  assign stall_m  = pending & (((state == IDLE) & MULTI) |
                               ((state == LOAD_WAIT) & (cnt != CNT_LAST)));
  assign complete = valid_m & ~flush_m & ~stall_m;
  assign we       = valid_m & mem_write_m & ~flush_m & in_range;

  dmem_bytewr #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .be    (byte_en_m),
    .idx   (idx),
    .wdata (write_data_m),
    .rdata (rdata)
  );

  // Load-latency FSM: counts the wait cycles of a multi-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush_m || !pending) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MULTI) begin
            state <= LOAD_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        LOAD_WAIT: begin
          if (at_last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Writeback registers: load on completion, bubble (hold data) otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w     <= 1'b0;
      alu_out_w   <= '0;
      read_data_w <= '0;
      err_w       <= 1'b0;
    end else begin
      valid_w <= complete;
      err_w   <= complete & is_mem & ~in_range;
      if (complete) begin
        alu_out_w   <= alu_out_m;
        read_data_w <= (mem_read_m & in_range) ? rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: one RD_LAT=1 and one RD_LAT=3 instance,
// completions checked against a scoreboard plus directed stall/bubble checks.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
  } in_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

`ifdef MEM_BOUNDS_CHK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk;
  logic rst;
  in_t  in1, in3;

  logic        stall1, vw1, err1;
  logic [31:0] alu1, rd1;
  logic        stall3, vw3, err3;
  logic [31:0] alu3, rd3;

  exp_t q1[$];
  exp_t q3[$];

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DATA_W(32), .DEPTH(64), .RD_LAT(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (in1.valid),
    .mem_read_m   (in1.rd),
    .mem_write_m  (in1.wr),
    .byte_en_m    (in1.be),
    .alu_out_m    (in1.addr),
    .write_data_m (in1.wdata),
    .flush_m      (in1.flush),
    .stall_m      (stall1),
    .valid_w      (vw1),
    .alu_out_w    (alu1),
    .read_data_w  (rd1),
    .err_w        (err1)
  );

  mem_wb_stage #(.DATA_W(32), .DEPTH(64), .RD_LAT(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (in3.valid),
    .mem_read_m   (in3.rd),
    .mem_write_m  (in3.wr),
    .byte_en_m    (in3.be),
    .alu_out_m    (in3.addr),
    .write_data_m (in3.wdata),
    .flush_m      (in3.flush),
    .stall_m      (stall3),
    .valid_w      (vw3),
    .alu_out_w    (alu3),
    .read_data_w  (rd3),
    .err_w        (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every valid writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && vw1) begin
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL sb1_unexpected observed alu=%h expected none", alu1);
      end
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("sb1_alu", alu1, e.alu);
        chk("sb1_rdata", rd1, e.rdat);
        chk("sb1_err", 32'(err1), 32'(e.err));
      end
    end
    if (!rst && vw3) begin
      checks++;
      assert (q3.size() > 0) else begin
        errors++;
        $error("FAIL sb3_unexpected observed alu=%h expected none", alu3);
      end
      if (q3.size() > 0) begin
        exp_t e;
        e = q3.pop_front();
        chk("sb3_alu", alu3, e.alu);
        chk("sb3_rdata", rd3, e.rdat);
        chk("sb3_err", 32'(err3), 32'(e.err));
      end
    end
  end

  // Single-cycle instruction on the RD_LAT=1 instance.
  task automatic op1(input string tag, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err);
    in1 = '{valid:1'b1, rd:rd, wr:wr, be:be, addr:addr, wdata:wdata, flush:1'b0};
    #1;
    chk({tag, "_stall"}, 32'(stall1), 32'd0);
    q1.push_back('{alu:addr, rdat:exp_rd, err:exp_err});
    tick();
    in1 = '0;
    chk({tag, "_valid_w"}, 32'(vw1), 32'd1);
  endtask

  // Single-cycle (non-load) instruction on the RD_LAT=3 instance.
  task automatic op3(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata);
    in3 = '{valid:1'b1, rd:1'b0, wr:wr, be:4'hF, addr:addr, wdata:wdata, flush:1'b0};
    #1;
    chk({tag, "_stall"}, 32'(stall3), 32'd0);
    q3.push_back('{alu:addr, rdat:32'd0, err:1'b0});
    tick();
    in3 = '0;
    chk({tag, "_valid_w"}, 32'(vw3), 32'd1);
  endtask

  // Three-cycle load: two stalled cycles with bubbles, then completion.
  task automatic load3(input string tag, input logic [31:0] addr, input logic [31:0] exp_rd,
                       input logic [31:0] prev_alu);
    in3 = '{valid:1'b1, rd:1'b1, wr:1'b0, be:4'h0, addr:addr, wdata:32'd0, flush:1'b0};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk({tag, "_stall_hi"}, 32'(stall3), 32'd1);
      tick();
      chk({tag, "_bubble"}, 32'(vw3), 32'd0);
      chk({tag, "_alu_hold"}, alu3, prev_alu);
    end
    #1;
    chk({tag, "_stall_lo"}, 32'(stall3), 32'd0);
    q3.push_back('{alu:addr, rdat:exp_rd, err:1'b0});
    tick();
    in3 = '0;
    chk({tag, "_valid_w"}, 32'(vw3), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in1 = '0;
    in3 = '0;
    tick();
    tick();
    chk("rst_valid_w", 32'(vw1), 32'd0);
    chk("rst_alu_w", alu1, 32'd0);
    chk("rst_rdata_w", rd1, 32'd0);
    chk("rst_err_w", 32'(err1), 32'd0);
    chk("rst_stall1", 32'(stall1), 32'd0);
    chk("rst_stall3", 32'(stall3), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall3", 32'(stall3), 32'd0);

    // Store then single-cycle load.
    op1("st_dead", 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    op1("ld_dead", 1'b1, 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    chk("ld_dead_direct", rd1, 32'hDEADBEEF);

    // Byte-lane store into word 4.
    op1("st_full", 1'b0, 1'b1, 4'hF, 32'h10, 32'h11223344, 32'd0, 1'b0);
    op1("st_lane", 1'b0, 1'b1, 4'h5, 32'h10, 32'hAABBCCDD, 32'd0, 1'b0);
    op1("ld_lane", 1'b1, 1'b0, 4'h0, 32'h13, 32'd0, 32'h11BB33DD, 1'b0);

    // Non-memory pass-through.
    op1("alu_pass", 1'b0, 1'b0, 4'h0, 32'h12345678, 32'd0, 32'd0, 1'b0);

    // Out-of-range address (word 256 with DEPTH=64).
    op1("st_zero", 1'b0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 32'd0, 1'b0);
    op1("st_oob", 1'b0, 1'b1, 4'hF, 32'h400, 32'h55667788, 32'd0, BC);
    op1("ld_zero", 1'b1, 1'b0, 4'h0, 32'h0, 32'd0, BC ? 32'hCAFEF00D : 32'h55667788, 1'b0);
    op1("ld_oob", 1'b1, 1'b0, 4'h0, 32'h400, 32'd0, BC ? 32'd0 : 32'h55667788, BC);

    // Idle cycle produces a bubble.
    tick();
    chk("idle_bubble", 32'(vw1), 32'd0);

    // RD_LAT=3: store, multi-cycle load, following instruction.
    op3("st3", 1'b1, 32'h20, 32'h0BADCAFE);
    load3("ld3", 32'h20, 32'h0BADCAFE, 32'h20);
    op3("alu3", 1'b0, 32'h77, 32'd0);

    // Flush in the second cycle of a load.
    in3 = '{valid:1'b1, rd:1'b1, wr:1'b0, be:4'h0, addr:32'h20, wdata:32'd0, flush:1'b0};
    #1;
    chk("fl_stall_c1", 32'(stall3), 32'd1);
    tick();
    in3.flush = 1'b1;
    #1;
    chk("fl_stall_drop", 32'(stall3), 32'd0);
    tick();
    in3 = '0;
    chk("fl_bubble", 32'(vw3), 32'd0);
    op3("fl_store", 1'b1, 32'h24, 32'h13579BDF);
    load3("fl_ld", 32'h24, 32'h13579BDF, 32'h24);

    // Reset during LOAD_WAIT.
    in3 = '{valid:1'b1, rd:1'b1, wr:1'b0, be:4'h0, addr:32'h20, wdata:32'd0, flush:1'b0};
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in3 = '0;
    #1;
    chk("rl_valid_w", 32'(vw3), 32'd0);
    chk("rl_alu_w", alu3, 32'd0);
    chk("rl_rdata_w", rd3, 32'd0);
    chk("rl_err_w", 32'(err3), 32'd0);
    chk("rl_stall", 32'(stall3), 32'd0);
    load3("rl_ld", 32'h24, 32'h13579BDF, 32'h0);

    @(negedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised memory-plus-writeback stage for the pipelined ARM core. It replaces the single-cycle data memory and the bare writeback registers. It adds the following:
- configurable data width and memory depth;
- byte-enabled stores;
- a configurable read latency with a stall handshake back to the pipeline;
- flush support;
- bubble insertion into writeback.

It sits between the execute/memory pipeline register and the register-file write port.

## Interface
Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 64, memory depth in words; must be a power of two.
- RD_LAT, 1, load latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- valid_m  in  1  M-stage holds a live instruction.
- mem_read_m  in  1  M instruction is a load.
- mem_write_m  in  1  M instruction is a store.
- byte_en_m  in  DATA_W/8  store byte lanes; bit i enables byte i.
- alu_out_m  in  32  byte address, or the ALU result for non-memory instructions.
- write_data_m  in  DATA_W  store data.
- flush_m  in  1  kills the current M instruction.
- stall_m  out  1  M stage must hold all inputs stable; upstream freezes.
- valid_w  out  1  W-stage registers hold a live result.
- alu_out_w  out  32  registered alu_out_m.
- read_data_w  out  DATA_W  registered load data.
- err_w  out  1  registered out-of-range flag (see Configuration).

## Operation
- Word index = alu_out_m[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]. Low byte-offset bits are ignored; no alignment fault.
- Store:
  - Executes in one cycle.
  - At the posedge with valid_m & mem_write_m & !flush_m, each enabled byte lane of mem[index] takes write_data_m.
  - Disabled lanes are unchanged.
  - A store never stalls.
- Load:
  - Returns the full word; no byte-lane masking.
  - The load is pending while valid_m & mem_read_m & !flush_m.
- Non-memory instruction: passes alu_out_m to alu_out_w with no stall.
- FSM has two states, IDLE and LOAD_WAIT, plus a wait counter cnt of width log2(RD_LAT)+1.
  - IDLE:
    - If a load is pending and RD_LAT>1, go to LOAD_WAIT with cnt=1.
    - Otherwise complete the instruction this cycle.
  - LOAD_WAIT:
    - cnt increments each cycle.
    - When cnt==RD_LAT-1, the load completes and the FSM returns to IDLE with cnt=0.
- stall_m = pending load & ((state==IDLE & RD_LAT>1) | (state==LOAD_WAIT & cnt!=RD_LAT-1)). The output is combinational.
- W registers update every cycle:
  - Instruction completing: valid_w<=1 and alu_out_w/read_data_w are loaded. read_data_w = mem[index] for a load, otherwise 0.
  - Stalled cycle: bubble, with valid_w<=0. alu_out_w and read_data_w hold their values.
- flush_m:
  - Suppresses any store.
  - Aborts a pending load: state<=IDLE, cnt<=0.
  - Forces valid_w<=0 at the next edge.
  - Deasserts stall_m in the same cycle.
- Memory contents are not cleared by reset.
- Reads see memory contents as of the cycle the load completes. Stores from the same instruction cannot coincide with a load.

## Timing
- Reset values: valid_w=0, alu_out_w=0, read_data_w=0, err_w=0, state=IDLE, cnt=0, stall_m=0.
- rst asserted mid-load drops the load. There is no stall in the cycle after reset.
- RD_LAT=1: the load occupies M for 1 cycle; data appears on read_data_w after the next posedge.
- RD_LAT=L: the load occupies M for L cycles, with stall_m high for the first L-1 of them. Data appears after the posedge ending cycle L.
- The next instruction enters M on the posedge after the completing cycle. Back-to-back loads restart the FSM from IDLE.
- Simultaneous rst and flush_m: rst wins. Both yield the same register state.

## Configuration
- MEM_BOUNDS_CHK_EN:
  - Defined: an address whose full word index (alu_out_m >> log2(DATA_W/8)) is >= DEPTH is out of range.
    - An out-of-range store is suppressed.
    - An out-of-range load returns 0.
    - err_w<=1 with the completing instruction; otherwise err_w<=0.
  - Undefined: the index is truncated, so addresses wrap modulo DEPTH words, and err_w is tied 0.

## Structure
- Shared package mem_pkg holds:
  - the FSM state enum (IDLE, LOAD_WAIT);
  - localparams BYTES = DATA_W/8 and IDX_W = log2(DEPTH);
  - the RD_LAT range check.
- One sub-module, dmem_bytewr: a byte-enabled synchronous-write / asynchronous-read word array. The stage owns the FSM, the latency counter and the W registers.

## Test plan
- Reset, then a store: store 0xDEADBEEF at address 0x10 with byte_en=0xF, then a load from 0x10 at RD_LAT=1 -> read_data_w=0xDEADBEEF and valid_w=1 one edge later, with stall_m never high.
- Byte-lane store: mem[4]=0x11223344, then a store of 0xAABBCCDD with byte_en=0x5 -> a later load returns 0x11BB33DD.
- RD_LAT=3 load -> stall_m high for exactly 2 cycles and valid_w=0 for those 2 edges. Data is valid after the 3rd edge and the next instruction enters on the following cycle.
- RD_LAT=3 load with flush_m in the second cycle -> stall_m drops that cycle, valid_w=0, FSM back in IDLE, and a following store executes normally.
- Out-of-range address 0x400 with DEPTH=64:
  - Macro defined: the store is ignored (mem[0] unchanged), and a load returns 0 with err_w=1.
  - Macro undefined: the address wraps to mem[0].
- rst asserted during LOAD_WAIT -> all outputs at reset values on the next edge, and stall_m=0.
